wb_cmd_master: RTL and testbench

Wishbone initiator that turns a byte-stream command channel (USB/UART debug pipe) into single register accesses on the 8-bit-address, 32-bit-data peripheral bus used by the misc/E1 peripherals. It parses the command, runs exactly one classic Wishbone cycle with a timeout, and streams back a status byte plus read data. It sits between the host byte pipe and the peripheral bus arbiter/decoder.

---
 rtl/wb_cmd_master.sv | 182 ++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: byte-stream command channel to single classic Wishbone accesses with timeout.
// Rev 1.0
`default_nettype none

module wb_cmd_master #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  wb_addr,
  input  logic [31:0] wb_rdata,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic        wb_cyc,
  input  logic        wb_ack,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BUS   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  len_q, len_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [7:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;
  logic        busy_q, busy_d;

  logic in_acc;
  logic out_acc;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    out_data_d = out_data_q;
    wb_addr_d  = wb_addr_q;
    wb_wdata_d = wb_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          // Only 0x00 (read) and 0x80 (write) are legal opcodes.
          if (in_data[6:0] == 7'd0) begin
            we_d    = in_data[7];
            state_d = S_ADDR;
          end else begin
            out_data_d = 8'h02;
            len_d      = 3'd1;
            idx_d      = 3'd0;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (in_acc) begin
          wb_addr_d = in_data;
          idx_d     = 3'd0;
          cnt_d     = 16'd0;
          state_d   = we_q ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (in_acc) begin
          wb_wdata_d[{idx_q[1:0], 3'b000} +: 8] = in_data;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd3) begin
            cnt_d   = 16'd0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (wb_ack) begin
          rdata_d    = we_q ? 32'd0 : wb_rdata;
          out_data_d = 8'h00;
          len_d      = we_q ? 3'd1 : 3'd5;
          idx_d      = 3'd0;
          state_d    = S_RESP;
        end else if (cnt_q + 16'd1 == TO_LIM) begin
          rdata_d    = 32'd0;
          out_data_d = 8'h01;
          len_d      = we_q ? 3'd1 : 3'd5;
          idx_d      = 3'd0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (out_acc) begin
          if (idx_q + 3'd1 == len_q) begin
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + 3'd1;
            out_data_d = rdata_q[{idx_q[1:0], 3'b000} +: 8];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake/bus outputs are registered images of the next state.
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    out_valid_d = (state_d == S_RESP);
    wb_cyc_d    = (state_d == S_BUS);
    wb_we_d     = (state_d == S_BUS) && we_d;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      len_q       <= 3'd0;
      we_q        <= 1'b0;
      rdata_q     <= 32'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 8'h00;
      wb_wdata_q  <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_wdata_q  <= wb_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_wdata  = wb_wdata_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: vector table plus scoreboard of response bytes for wb_cmd_master.
// Rev 1.0
`default_nettype none

module tb_wb_cmd_master;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic        busy;

  wb_cmd_master #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] cmd;
    int          ncmd;
    int          ack_at;
    logic [31:0] rdata;
    int          pulses;
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    int          cyclen;
    logic [39:0] rsp;
    int          nrsp;
  } vec_t;

  vec_t vecs[8];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // slave model state
  int          ack_at = 0;
  int          cyc_cnt = 0;
  int          pulses = 0;
  int          last_len = 0;
  logic [7:0]  cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  logic        unstable = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Wishbone slave: acks in the ack_at-th cycle of wb_cyc, never when ack_at is 0.
  initial begin
    wb_ack = 1'b0;
    wb_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (wb_cyc) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          cap_addr  = wb_addr;
          cap_we    = wb_we;
          cap_wdata = wb_wdata;
        end else if (wb_addr !== cap_addr || wb_we !== cap_we || wb_wdata !== cap_wdata) begin
          unstable = 1'b1;
        end
        wb_ack = (ack_at != 0) && (cyc_cnt == ack_at);
      end else begin
        if (cyc_cnt != 0) begin
          pulses++;
          last_len = cyc_cnt;
        end
        cyc_cnt = 0;
        wb_ack = 1'b0;
      end
    end
  end

  // Response collector: pops the scoreboard on each handshake and checks stalls hold.
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {24'd0, out_data}, {24'd0, hold_data});
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_resp_byte: got %h expected none", out_data);
          end else begin
            chk("resp_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("send_byte");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now("wait_idle");
  endtask

  task automatic run_vec(input int i);
    ack_at   = vecs[i].ack_at;
    wb_rdata = vecs[i].rdata;
    pulses   = 0;
    last_len = 0;
    unstable = 1'b0;
    for (int k = 0; k < vecs[i].nrsp; k++) exp_q.push_back(vecs[i].rsp[8*k +: 8]);
    for (int k = 0; k < vecs[i].ncmd; k++) send_byte(vecs[i].cmd[8*k +: 8]);
    wait_idle();
    chk($sformatf("v%0d_pulses", i), pulses, vecs[i].pulses);
    if (vecs[i].pulses != 0) begin
      chk($sformatf("v%0d_addr", i), {24'd0, cap_addr}, {24'd0, vecs[i].addr});
      chk($sformatf("v%0d_we", i), {31'd0, cap_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_cyclen", i), last_len, vecs[i].cyclen);
      chk($sformatf("v%0d_stable", i), {31'd0, unstable}, 32'd0);
    end
    chk($sformatf("v%0d_we_after", i), {31'd0, wb_we}, 32'd0);
    chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
  endtask

  task automatic set_vec(input int i, input logic [47:0] cmd, input int ncmd, input int ack,
                         input logic [31:0] rd, input int pls, input logic [7:0] addr,
                         input logic we, input logic [31:0] wd, input int cl,
                         input logic [39:0] rsp, input int nrsp);
    vecs[i].cmd = cmd;    vecs[i].ncmd = ncmd;  vecs[i].ack_at = ack;
    vecs[i].rdata = rd;   vecs[i].pulses = pls; vecs[i].addr = addr;
    vecs[i].we = we;      vecs[i].wdata = wd;   vecs[i].cyclen = cl;
    vecs[i].rsp = rsp;    vecs[i].nrsp = nrsp;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

    set_vec(0, 48'h80_00_0A_BC_08_80, 6, 1,  32'h0,        1, 8'h08, 1'b1, 32'h80000ABC, 1,  40'h00, 1);
    set_vec(1, 48'h07_00,             2, 1,  32'h12345678, 1, 8'h07, 1'b0, 32'h0,        1,  40'h12_34_56_78_00, 5);
    set_vec(2, 48'h3F_00,             2, 0,  32'hDEADBEEF, 1, 8'h3F, 1'b0, 32'h0,        64, 40'h00_00_00_00_01, 5);
    set_vec(3, 48'h3F_00,             2, 64, 32'hCAFEF00D, 1, 8'h3F, 1'b0, 32'h0,        64, 40'hCA_FE_F0_0D_00, 5);
    set_vec(4, 48'h41,                1, 1,  32'h0,        0, 8'h00, 1'b0, 32'h0,        0,  40'h02, 1);
    set_vec(5, 48'h10_00,             2, 3,  32'hA5A50001, 1, 8'h10, 1'b0, 32'h0,        3,  40'hA5_A5_00_01_00, 5);
    set_vec(6, 48'h44_33_22_11_FF_80, 6, 0,  32'h0,        1, 8'hFF, 1'b1, 32'h44332211, 64, 40'h01, 1);
    set_vec(7, 48'hFF,                1, 1,  32'h0,        0, 8'h00, 1'b0, 32'h0,        0,  40'h02, 1);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", {24'd0, wb_addr}, 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // backpressure: stall each response byte 10 cycles while offering junk input bytes
    ack_at = 2;
    wb_rdata = 32'h0BADBEEF;
    out_ready = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    send_byte(8'h00);
    send_byte(8'h20);
    in_valid = 1'b1;
    in_data  = 8'h41;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      chk("bus_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("bp_wait_valid");
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 10; c++) begin
        @(posedge clk);
        #1;
        chk("resp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      if (b < 4) in_valid = 1'b1;
    end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

    // reset during a bus cycle
    ack_at = 0;
    exp_q.push_back(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    n = 0;
    while (!wb_cyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("mid_wait_cyc");
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
